// File: rtl/sha256_multiblock_core_pkg.sv
// Shared types, constants and helpers for the SHA-256/224 multi-block core:
// state encoding, register map, round constants and initial hash values.
package sha256_multiblock_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [31:0] word_t;
  // Element 0 is working variable a / H0; element 7 is h / H7.
  typedef logic [7:0][31:0]  hash_t;
  // Element 0 is W[t], element 15 is W[t+15].
  typedef logic [15:0][31:0] win_t;

  localparam logic [6:0] ADDR_W_LAST    = 7'd63;
  localparam logic [6:0] ADDR_WHO       = 7'd64;
  localparam logic [6:0] ADDR_CTRL      = 7'd65;
  localparam logic [6:0] ADDR_REV       = 7'd66;
  localparam logic [6:0] ADDR_DIG_FIRST = 7'd70;
  localparam logic [6:0] ADDR_DIG_LAST  = 7'd101;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_CONT    = 1;
  localparam int unsigned CTRL_MODE224 = 2;
  localparam int unsigned CTRL_IRQ_CLR = 3;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t k_const(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  function automatic hash_t iv(input logic mode224);
    hash_t h;
    for (int unsigned i = 0; i < 8; i++) h[i] = mode224 ? IV224[i] : IV256[i];
    return h;
  endfunction

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_multiblock_core_round.sv
// One combinational SHA-256 round: updates the eight working variables and
// slides the 16-word message schedule window forward by one word.
module sha256_round
  import sha256_multiblock_core_pkg::*;
(
  input  hash_t vars_i,
  input  win_t  win_i,
  input  word_t k_i,
  output hash_t vars_o,
  output win_t  win_o
);

  word_t bs0, bs1, ch, maj, t1, t2, ss0, ss1;

  always_comb begin
    bs1 = rotr(vars_i[4], 6) ^ rotr(vars_i[4], 11) ^ rotr(vars_i[4], 25);
    ch  = (vars_i[4] & vars_i[5]) ^ (~vars_i[4] & vars_i[6]);
    t1  = vars_i[7] + bs1 + ch + k_i + win_i[0];
    bs0 = rotr(vars_i[0], 2) ^ rotr(vars_i[0], 13) ^ rotr(vars_i[0], 22);
    maj = (vars_i[0] & vars_i[1]) ^ (vars_i[0] & vars_i[2]) ^ (vars_i[1] & vars_i[2]);
    t2  = bs0 + maj;

    vars_o[0] = t1 + t2;
    vars_o[1] = vars_i[0];
    vars_o[2] = vars_i[1];
    vars_o[3] = vars_i[2];
    vars_o[4] = vars_i[3] + t1;
    vars_o[5] = vars_i[4];
    vars_o[6] = vars_i[5];
    vars_o[7] = vars_i[6];

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    ss0 = rotr(win_i[1], 7) ^ rotr(win_i[1], 18) ^ (win_i[1] >> 3);
    ss1 = rotr(win_i[14], 17) ^ rotr(win_i[14], 19) ^ (win_i[14] >> 10);
    win_o[14:0] = win_i[15:1];
    win_o[15]   = ss1 + win_i[9] + ss0 + win_i[0];
  end

endmodule

// File: rtl/sha256_multiblock_core.sv
// Byte-addressed SHA-256/SHA-224 compression engine with digest chaining
// across blocks; ROUNDS_PER_CLK rounds are unrolled per ROUND cycle.
module sha256_multiblock_core
  import sha256_multiblock_core_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CLK = 1,
  parameter bit          ENABLE_SHA224  = 1'b1,
  parameter logic [7:0]  REVISION_DATA  = 8'd53
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_w_addr,
  input  logic [7:0] i_data8,
  input  logic       i_we,
  output logic [7:0] o_data_mux,
  output logic       o_irq
);

  localparam int unsigned R          = ROUNDS_PER_CLK;
  localparam logic [5:0]  LAST_ROUND = 6'(64 - R);
  localparam logic [5:0]  ROUND_STEP = 6'(R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
    $error("ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
  end

  state_e     state_q, state_d;
  logic [5:0] round_q;
  hash_t      vars_q, hin_q, digest_q;
  win_t       w_q;
  logic       mode_q, dig_valid_q;

  logic busy, ctrl_wr, w_wr, start_go, cont_go, irq_clr, start_mode;

  hash_t vars_c [R+1];
  win_t  win_c  [R+1];

  assign vars_c[0] = vars_q;
  assign win_c[0]  = w_q;

  for (genvar gi = 0; gi < R; gi++) begin : g_round
    sha256_round u_round (
      .vars_i (vars_c[gi]),
      .win_i  (win_c[gi]),
      .k_i    (k_const(round_q + 6'(gi))),
      .vars_o (vars_c[gi+1]),
      .win_o  (win_c[gi+1])
    );
  end

  // A CONTINUE with no completed digest behind it restarts from the IV.
  always_comb begin
    ctrl_wr    = i_we && (i_w_addr == ADDR_CTRL) && !busy;
    w_wr       = i_we && (i_w_addr <= ADDR_W_LAST) && !busy;
    start_go   = ctrl_wr && (i_data8[CTRL_START] || (i_data8[CTRL_CONT] && !dig_valid_q));
    cont_go    = ctrl_wr && !i_data8[CTRL_START] && i_data8[CTRL_CONT] && dig_valid_q;
    irq_clr    = ctrl_wr && i_data8[CTRL_IRQ_CLR];
    start_mode = ENABLE_SHA224 && i_data8[CTRL_MODE224];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_go || cont_go) state_d = ST_ROUND;
      ST_ROUND: if (round_q == LAST_ROUND) state_d = ST_ADD;
      ST_ADD:   state_d = ST_DONE;
      ST_DONE: begin
        if (start_go || cont_go) state_d = ST_ROUND;
        else if (irq_clr)        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_irq = (state_q == ST_DONE);
    busy  = (state_q == ST_ROUND) || (state_q == ST_ADD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      round_q     <= '0;
      vars_q      <= '0;
      hin_q       <= '0;
      digest_q    <= '0;
      w_q         <= '0;
      mode_q      <= 1'b0;
      dig_valid_q <= 1'b0;
    end else begin
      if (start_go) begin
        vars_q  <= iv(start_mode);
        hin_q   <= iv(start_mode);
        mode_q  <= start_mode;
        round_q <= '0;
      end else if (cont_go) begin
        vars_q  <= digest_q;
        hin_q   <= digest_q;
        round_q <= '0;
      end else if (state_q == ST_ROUND) begin
        vars_q  <= vars_c[R];
        w_q     <= win_c[R];
        round_q <= round_q + ROUND_STEP;
      end else if (state_q == ST_ADD) begin
        for (int unsigned i = 0; i < 8; i++) digest_q[i] <= vars_q[i] + hin_q[i];
        dig_valid_q <= 1'b1;
      end
      if (w_wr) w_q[i_w_addr[5:2]][{~i_w_addr[1:0], 3'b000} +: 8] <= i_data8;
    end
  end

  logic [4:0] dig_off;
  word_t      dig_word;

  always_comb begin
    o_data_mux = 8'hAA;
    dig_off    = 5'(i_w_addr - ADDR_DIG_FIRST);
    dig_word   = digest_q[dig_off[4:2]];
    if (i_w_addr <= ADDR_W_LAST) begin
      o_data_mux = '0;
    end else if (i_w_addr == ADDR_WHO) begin
      o_data_mux = 8'(R);
    end else if (i_w_addr == ADDR_CTRL) begin
      o_data_mux = {2'b00, state_q, state_q == ST_DONE, busy, dig_valid_q, mode_q};
    end else if (i_w_addr == ADDR_REV) begin
      o_data_mux = REVISION_DATA;
    end else if (i_w_addr >= ADDR_DIG_FIRST && i_w_addr <= ADDR_DIG_LAST) begin
      // H7 is kept for chaining but hidden from the SHA-224 digest view.
      if (mode_q && dig_off[4:2] == 3'd7) o_data_mux = '0;
      else                                o_data_mux = dig_word[{~dig_off[1:0], 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Directed bench for sha256_multiblock_core: known-answer digests, chaining,
// SHA-224, latency for R=1 and R=4, busy-write rejection and mid-run reset.
module tb_sha256_multiblock_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] addr;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout1, dout4;
  logic       irq1, irq4;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]  blk [64];
  logic [31:0] EXP_ABC [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] EXP_TWO [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  logic [31:0] EXP_224 [8] = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                               32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};

  always #5 clk = ~clk;

  sha256_multiblock_core #(.ROUNDS_PER_CLK(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_w_addr(addr), .i_data8(din), .i_we(we),
    .o_data_mux(dout1), .o_irq(irq1)
  );

  sha256_multiblock_core #(.ROUNDS_PER_CLK(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_w_addr(addr), .i_data8(din), .i_we(we),
    .o_data_mux(dout4), .o_irq(irq4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v1, output logic [7:0] v4);
    addr = a;
    #1;
    v1 = dout1;
    v4 = dout4;
  endtask

  task automatic rd_word(input int w, output logic [31:0] v1, output logic [31:0] v4);
    logic [7:0] b1, b4;
    v1 = '0; v4 = '0;
    for (int b = 0; b < 4; b++) begin
      rd(7'(70 + 4 * w + b), b1, b4);
      v1 = {v1[23:0], b1};
      v4 = {v4[23:0], b4};
    end
  endtask

  task automatic load_blk();
    for (int i = 0; i < 64; i++) wr(7'(i), blk[i]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[0] = 8'h61; blk[1] = 8'h62; blk[2] = 8'h63; blk[3] = 8'h80; blk[63] = 8'h18;
  endtask

  task automatic set_two1();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < 56; i++) blk[i] = 8'(8'h61 + i / 4 + i % 4);
    blk[56] = 8'h80;
  endtask

  task automatic set_two2();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[62] = 8'h01; blk[63] = 8'hc0;
  endtask

  // Cycle k is the clock period ending with edge N+k after the CTRL write edge N.
  task automatic wait_irq(output int c1, output int c4);
    c1 = 0; c4 = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (irq4 && c4 == 0) c4 = cyc;
      if (irq1) begin
        c1 = cyc;
        break;
      end
    end
  endtask

  task automatic check_digest(input string tag, input logic [31:0] e [8], input bit also4);
    logic [31:0] v1, v4;
    for (int w = 0; w < 8; w++) begin
      rd_word(w, v1, v4);
      check($sformatf("%s_h%0d", tag, w), v1, e[w]);
      if (also4) check($sformatf("%s_r4_h%0d", tag, w), v4, e[w]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v1, v4;
    logic [31:0] x1, x4;
    int c1, c4;

    rst = 1'b1; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rd(7'd65, v1, v4);  check("rst_status", v1, 8'h00);
    check("rst_irq", irq1, 1'b0);
    rd(7'd64, v1, v4);  check("who_r1", v1, 8'h01); check("who_r4", v4, 8'h04);
    rd(7'd66, v1, v4);  check("revision", v1, 8'd53);
    rd(7'd67, v1, v4);  check("unmapped_67", v1, 8'hAA);
    rd(7'd120, v1, v4); check("unmapped_120", v1, 8'hAA);
    rd(7'd5, v1, v4);   check("wblock_read", v1, 8'h00);
    rd(7'd70, v1, v4);  check("rst_digest", v1, 8'h00);

    // "abc", fresh message, both builds
    set_abc(); load_blk();
    wr(7'd65, 8'h01);
    wait_irq(c1, c4);
    check("abc_lat_r1", c1, 66);
    check("abc_lat_r4", c4, 18);
    check_digest("abc", EXP_ABC, 1'b1);
    rd(7'd65, v1, v4); check("abc_status", v1 & 8'hFD, 8'h38);

    wr(7'd65, 8'h08);
    rd(7'd65, v1, v4); check("irqclr_status", v1 & 8'hFD, 8'h00);
    check("irqclr_irq", irq1, 1'b0);
    rd_word(0, x1, x4); check("irqclr_keep_h0", x1, 32'hba7816bf);

    // Two-block message chained through CONTINUE
    set_two1(); load_blk();
    wr(7'd65, 8'h01);
    wait_irq(c1, c4); check("two_b1_lat", c1, 66);
    wr(7'd65, 8'h08);
    set_two2(); load_blk();
    wr(7'd65, 8'h02);
    wait_irq(c1, c4); check("two_b2_lat", c1, 66);
    check_digest("two", EXP_TWO, 1'b0);

    // SHA-224 started directly from DONE
    set_abc(); load_blk();
    wr(7'd65, 8'h05);
    wait_irq(c1, c4); check("sha224_lat", c1, 66);
    check_digest("sha224", EXP_224, 1'b0);
    rd(7'd65, v1, v4); check("sha224_status", v1 & 8'hFD, 8'h39);

    // Writes while busy must be ignored
    wr(7'd65, 8'h08);
    set_abc(); load_blk();
    wr(7'd65, 8'h01);
    repeat (8) @(posedge clk);
    #1;
    rd(7'd65, v1, v4); check("busy_status", v1 & 8'h3C, 8'h14);
    wr(7'd5, 8'hFF);
    wr(7'd65, 8'h01);
    wait_irq(c1, c4); check("busy_lat", c1, 56);
    check_digest("busy", EXP_ABC, 1'b0);

    // Reset around round 30, then a clean run
    set_abc(); load_blk();
    wr(7'd65, 8'h01);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rd(7'd65, v1, v4);  check("midrst_status", v1, 8'h00);
    check("midrst_irq", irq1, 1'b0);
    rd(7'd70, v1, v4);  check("midrst_digest70", v1, 8'h00);
    rd(7'd101, v1, v4); check("midrst_digest101", v1, 8'h00);
    rd(7'd64, v1, v4);  check("midrst_who", v1, 8'h01);
    set_abc(); load_blk();
    wr(7'd65, 8'h01);
    wait_irq(c1, c4); check("postrst_lat", c1, 66);
    check_digest("postrst", EXP_ABC, 1'b0);

    // CONTINUE with no valid digest behaves as START
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_abc(); load_blk();
    wr(7'd65, 8'h02);
    wait_irq(c1, c4); check("cont_nodig_lat", c1, 66);
    rd_word(0, x1, x4); check("cont_nodig_h0", x1, EXP_ABC[0]);
    rd_word(7, x1, x4); check("cont_nodig_h7", x1, EXP_ABC[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
